rtc_calendar_core: RTL and testbench

// - Timekeeping/calendar stage feeding the LCD display controller: 24 h time (hh:mm:ss) and date 20YY-MM-DD.
// - Counts seconds from a CLK prescaler.
// - Applies per-field user increments while MODE selects a current-time control field.
// - Presents every field as registered ASCII digit pairs ('0'=8'h30), ready for the display controller.

---
 rtl/rtc_calendar_core.sv | 231 +++++++++++++++++++++++
 tb/tb_rtc_calendar_core.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core
//   Real-time clock and calendar stage for the LCD display controller.
//   It keeps 24 h time (hh:mm:ss) and the date 20YY-MM-DD. A CLK prescaler
//   advances the seconds, and a carry chain ripples the change up to the year.
//   While MODE selects a current-time control field, counting is frozen and
//   each INC cycle advances that field by one. Every field is presented as a
//   registered ASCII digit pair ('0' = 8'h30). The pair lags the binary
//   registers by one cycle.
//
//   Parameter
//     CLK_FREQ  CLK cycles per second (prescaler terminal count = CLK_FREQ-1)
//
//   Ports
//     CLK, RESETN              clock; synchronous active-low reset
//     MODE[5:0]                UI mode (0x1X = control field, freezes counting)
//     INC                      one-cycle increment for the selected field
//     SEC_TICK                 one-cycle pulse, high in the cycle the new second is held
//     H10..S1                  ASCII time digits
//     Y10..D1                  ASCII date digits (MT = month)
//
//   Build option
//     RTC_LEAP_YEAR_EN  defined: February has 29 days when year[1:0]==0.
//                       undefined: February always has 28 days.

// Binary 0..99 to ASCII tens/ones digit pair (combinational).
module rtc_ascii_pair (
  input  logic [6:0] val,
  output logic [7:0] tens,
  output logic [7:0] ones
);
  logic [6:0] q, r;
  assign q    = val / 7'd10;
  assign r    = val % 7'd10;
  assign tens = 8'h30 + {1'b0, q};
  assign ones = 8'h30 + {1'b0, r};
endmodule

module rtc_calendar_core #(
  parameter int CLK_FREQ = 50000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [5:0] MODE,
  input  logic       INC,
  output logic       SEC_TICK,
  output logic [7:0] H10,
  output logic [7:0] H1,
  output logic [7:0] M10,
  output logic [7:0] M1,
  output logic [7:0] S10,
  output logic [7:0] S1,
  output logic [7:0] Y10,
  output logic [7:0] Y1,
  output logic [7:0] MT10,
  output logic [7:0] MT1,
  output logic [7:0] D10,
  output logic [7:0] D1
);

  localparam int            PW     = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_FREQ - 1);
  localparam int            NUM_FIELDS = 6;

  localparam logic [5:0] CTRL_HOUR  = 6'h13;
  localparam logic [5:0] CTRL_MIN   = 6'h15;
  localparam logic [5:0] CTRL_SEC   = 6'h17;
  localparam logic [5:0] CTRL_YEAR  = 6'h1B;
  localparam logic [5:0] CTRL_MONTH = 6'h1D;
  localparam logic [5:0] CTRL_DAY   = 6'h1F;

  // Field order: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year; [1]=tens [0]=ones.
  localparam logic [NUM_FIELDS-1:0][1:0][7:0] ASC_RST = {
    8'h30, 8'h30,   // year  00
    8'h30, 8'h31,   // month 01
    8'h30, 8'h31,   // day   01
    8'h30, 8'h30,   // hour
    8'h30, 8'h30,   // min
    8'h30, 8'h30    // sec
  };

  logic [PW-1:0] presc, presc_n;
  logic [5:0]    sec, sec_n, min, min_n;
  logic [4:0]    hour, hour_n, day, day_n;
  logic [3:0]    month, month_n;
  logic [6:0]    year, year_n;
  logic          freeze, tick;
  logic          leap_cur, leap_nxt;
  logic [4:0]    dim_cur, dim_nxt;

  logic [NUM_FIELDS-1:0][6:0]      fval;
  logic [NUM_FIELDS-1:0][1:0][7:0] asc_d, asc_q;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                         days_in_month = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:      days_in_month = 5'd30;
      default:                      days_in_month = 5'd31;
    endcase
  endfunction

  // Only the control-field block (0x1X) freezes; alarm modes keep counting.
  assign freeze = (MODE[5:4] == 2'b01);

  always_comb begin
    presc_n = presc;
    sec_n   = sec;
    min_n   = min;
    hour_n  = hour;
    day_n   = day;
    month_n = month;
    year_n  = year;
    tick    = 1'b0;

`ifdef RTC_LEAP_YEAR_EN
    leap_cur = (year[1:0] == 2'b00);
`else
    leap_cur = 1'b0;
`endif
    dim_cur = days_in_month(month, leap_cur);

    if (!freeze) begin
      if (presc == PRE_TC) begin
        tick    = 1'b1;
        presc_n = '0;
        if (sec == 6'd59) begin
          sec_n = '0;
          if (min == 6'd59) begin
            min_n = '0;
            if (hour == 5'd23) begin
              hour_n = '0;
              if (day >= dim_cur) begin
                day_n = 5'd1;
                if (month >= 4'd12) begin
                  month_n = 4'd1;
                  year_n  = (year >= 7'd99) ? 7'd0 : year + 7'd1;
                end else begin
                  month_n = month + 4'd1;
                end
              end else begin
                day_n = day + 5'd1;
              end
            end else begin
              hour_n = hour + 5'd1;
            end
          end else begin
            min_n = min + 6'd1;
          end
        end else begin
          sec_n = sec + 6'd1;
        end
      end else begin
        presc_n = presc + PW'(1);
      end
    end else if (INC) begin
      case (MODE)
        CTRL_SEC: begin
          sec_n   = (sec >= 6'd59) ? 6'd0 : sec + 6'd1;
          presc_n = '0;   // restart the second so the edited value is held a full second
        end
        CTRL_MIN:   min_n   = (min   >= 6'd59)  ? 6'd0 : min + 6'd1;
        CTRL_HOUR:  hour_n  = (hour  >= 5'd23)  ? 5'd0 : hour + 5'd1;
        CTRL_DAY:   day_n   = (day   >= dim_cur) ? 5'd1 : day + 5'd1;
        CTRL_MONTH: month_n = (month >= 4'd12)  ? 4'd1 : month + 4'd1;
        CTRL_YEAR:  year_n  = (year  >= 7'd99)  ? 7'd0 : year + 7'd1;
        default: ;
      endcase
    end

    // A month or year change can shorten the month under the current day.
`ifdef RTC_LEAP_YEAR_EN
    leap_nxt = (year_n[1:0] == 2'b00);
`else
    leap_nxt = 1'b0;
`endif
    dim_nxt = days_in_month(month_n, leap_nxt);
    if (day_n > dim_nxt) day_n = dim_nxt;
  end

  assign fval[0] = {1'b0, sec};
  assign fval[1] = {1'b0, min};
  assign fval[2] = {2'b0, hour};
  assign fval[3] = {2'b0, day};
  assign fval[4] = {3'b0, month};
  assign fval[5] = year;

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_ascii
    rtc_ascii_pair u_pair (
      .val  (fval[i]),
      .tens (asc_d[i][1]),
      .ones (asc_d[i][0])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      presc    <= '0;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      day      <= 5'd1;
      month    <= 4'd1;
      year     <= '0;
      SEC_TICK <= 1'b0;
      asc_q    <= ASC_RST;
    end else begin
      presc    <= presc_n;
      sec      <= sec_n;
      min      <= min_n;
      hour     <= hour_n;
      day      <= day_n;
      month    <= month_n;
      year     <= year_n;
      SEC_TICK <= tick;
      asc_q    <= asc_d;
    end
  end

  assign S10  = asc_q[0][1];
  assign S1   = asc_q[0][0];
  assign M10  = asc_q[1][1];
  assign M1   = asc_q[1][0];
  assign H10  = asc_q[2][1];
  assign H1   = asc_q[2][0];
  assign D10  = asc_q[3][1];
  assign D1   = asc_q[3][0];
  assign MT10 = asc_q[4][1];
  assign MT1  = asc_q[4][0];
  assign Y10  = asc_q[5][1];
  assign Y1   = asc_q[5][0];

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed testbench for rtc_calendar_core with a 10-cycle second.
// Inputs change and outputs are sampled on the falling edge.
module tb_rtc_calendar_core;

  localparam int F = 10;

  logic       CLK = 1'b0;
  logic       RESETN, INC, SEC_TICK;
  logic [5:0] MODE;
  logic [7:0] H10, H1, M10, M1, S10, S1, Y10, Y1, MT10, MT1, D10, D1;
  logic [47:0] tim, dat, exp_dat;

  int tests = 0, fails = 0, tick_seen = 0;

  rtc_calendar_core #(.CLK_FREQ(F)) dut (
    .CLK(CLK), .RESETN(RESETN), .MODE(MODE), .INC(INC), .SEC_TICK(SEC_TICK),
    .H10(H10), .H1(H1), .M10(M10), .M1(M1), .S10(S10), .S1(S1),
    .Y10(Y10), .Y1(Y1), .MT10(MT10), .MT1(MT1), .D10(D10), .D1(D1)
  );

  always #5 CLK = ~CLK;

  assign tim = {H10, H1, M10, M1, S10, S1};
  assign dat = {Y10, Y1, MT10, MT1, D10, D1};

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (SEC_TICK) tick_seen++;
    end
  endtask

  task automatic inc_n(input logic [5:0] m, input int n);
    MODE = m;
    INC  = 1'b1;
    cyc(n);
    INC  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RESETN = 1'b0; MODE = 6'h00; INC = 1'b0;
    cyc(2);
    chk("rst_tick", 48'(SEC_TICK), 48'd0);
    chk("rst_time", tim, "000000");
    chk("rst_date", dat, "000101");

    // Free-run three seconds
    RESETN = 1'b1; tick_seen = 0;
    cyc(29);
    chk("run_s1_2", tim, "000002");
    cyc(1);
    chk("tick3_pulse", 48'(SEC_TICK), 48'd1);
    chk("tick3_lag", tim, "000002");
    cyc(1);
    chk("tick_count", 48'(tick_seen), 48'd3);
    chk("run_s1_3", tim, "000003");

    // 25 hour increments wrap to 01, nothing else moves, no ticks
    tick_seen = 0;
    inc_n(6'h13, 25); cyc(1);
    chk("hour25_time", tim, "010003");
    chk("hour25_date", dat, "000101");
    chk("hour25_notick", 48'(tick_seen), 48'd0);

    // Load 23:59:59 2099-12-31
    inc_n(6'h13, 22); inc_n(6'h15, 59); inc_n(6'h17, 56);
    inc_n(6'h1B, 99); inc_n(6'h1D, 11); inc_n(6'h1F, 30); cyc(1);
    chk("load_time", tim, "235959");
    chk("load_date", dat, "991231");
    MODE = 6'h00;
    cyc(10);
    chk("roll_pulse", 48'(SEC_TICK), 48'd1);
    chk("roll_lag", tim, "235959");
    cyc(1);
    chk("roll_time", tim, "000000");
    chk("roll_date", dat, "000101");

    // Jan 31 year 04, month INC clamps the day
    inc_n(6'h1F, 30); inc_n(6'h1B, 4); cyc(1);
    chk("jan31", dat, "040131");
    inc_n(6'h1D, 1); cyc(1);
`ifdef RTC_LEAP_YEAR_EN
    chk("month_clamp", dat, "040229");
`else
    chk("month_clamp", dat, "040228");
`endif

    // Year change to 01 (non-leap) clamps or keeps Feb 28
    inc_n(6'h1B, 97); cyc(1);
    chk("year_clamp", dat, "010228");
    inc_n(6'h13, 23); inc_n(6'h15, 59); inc_n(6'h17, 59); cyc(1);
    chk("feb28_time", tim, "235959");
    MODE = 6'h00;
    cyc(11);
    chk("feb_roll_date", dat, "010301");
    chk("feb_roll_time", tim, "000000");

    // Feb 28 2000 rollover
    inc_n(6'h1B, 99); inc_n(6'h1D, 11); inc_n(6'h1F, 27);
    inc_n(6'h13, 23); inc_n(6'h15, 59); inc_n(6'h17, 59); cyc(1);
    chk("y00_feb28", dat, "000228");
    MODE = 6'h00;
    cyc(11);
`ifdef RTC_LEAP_YEAR_EN
    exp_dat = "000229";
`else
    exp_dat = "000301";
`endif
    chk("y00_roll_date", dat, exp_dat);

    // Undefined control code: frozen, INC ignored
    tick_seen = 0;
    inc_n(6'h11, 5); cyc(1);
    chk("undef_time", tim, "000000");
    chk("undef_date", dat, exp_dat);
    chk("undef_notick", 48'(tick_seen), 48'd0);

    // Alarm mode: INC ignored, seconds keep counting (prescaler is at 1)
    inc_n(6'h21, 9); cyc(1);
    chk("alarm_tick", 48'(tick_seen), 48'd1);
    chk("alarm_time", tim, "000001");
    chk("alarm_date", dat, exp_dat);

    // Reset on the edge that would otherwise tick
    cyc(8);
    RESETN = 1'b0;
    cyc(1);
    chk("mid_rst_tick", 48'(SEC_TICK), 48'd0);
    chk("mid_rst_time", tim, "000000");
    chk("mid_rst_date", dat, "000101");
    RESETN = 1'b1; tick_seen = 0;
    cyc(9);
    chk("post_rst_notick", 48'(tick_seen), 48'd0);
    cyc(1);
    chk("post_rst_tick", 48'(SEC_TICK), 48'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
